result_accumulator: RTL and testbench
=====================================

# result_accumulator

Downstream stage of the adder DUT: consumes the adder's result stream over a valid/ready handshake, sums a burst of `BURST` consecutive results into a wider unsigned total, and emits that total together with a beat count over its own valid/ready handshake. A `flush` input closes a partial burst early. The current FSM state is exported for debug, matching the adder DUT.

## Interface
- `IN_W`, default 9: width of the incoming adder result (unsigned).
- `BURST`, default 4: number of results per accumulation; must be ≥ 2.
- `OUT_W`, derived localparam: `IN_W + $clog2(BURST)`; width of the emitted total.
- `CNT_W`, derived localparam: `$clog2(BURST+1)`; width of the beat count.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  IN_W  adder result.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a result this cycle (registered).
- `flush`  in  1  close the current partial burst.
- `out_data`  out  OUT_W  accumulated total.
- `out_count`  out  CNT_W  number of results summed into `out_data`.
- `out_valid`  out  1  `out_data`/`out_count` are valid.
- `out_ready`  in  1  sink accepts the output.
- `state`  out  2  FSM state: IDLE=00, ACCUM=01, SEND=10.

## Operation
- **Reset** (`rst`=0, no clock needed): clears everything immediately.
  - Outputs: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_count`=0, `state`=IDLE.
  - Internal accumulator and beat counter = 0. Any partial burst is discarded.
- **IDLE**: unconditionally sets `in_ready`<=1 and goes to ACCUM (one cycle after reset release).
- **ACCUM**: an accept is `in_valid && in_ready`.
  - On accept: accumulator += `in_data`, counter += 1.
  - On the accept that brings the counter to `BURST`:
    - `out_data` <= accumulator + `in_data`, `out_count` <= `BURST`, `out_valid` <= 1;
    - `in_ready` <= 0; accumulator and counter <= 0; go to SEND.
  - `flush`=1 with counter > 0 (counted after any same-cycle accept): emit the partial sum.
    - Same register updates as a full burst, but `out_count` = number of beats accepted, including a same-cycle accept.
  - `flush`=1 with counter = 0 and no accept: ignored, stay in ACCUM.
  - `flush` on the `BURST`-th beat: same as a normal full burst.
  - With `in_valid`=0: hold all state; `in_data` is don't-care (may be X) and is never accumulated.
- **SEND**:
  - `out_valid`, `out_data` and `out_count` are held stable until `out_ready`=1.
  - On `out_ready`: `out_valid` <= 0, `in_ready` <= 1, go to ACCUM.
  - `in_valid` and `flush` are ignored in SEND.
- **Arithmetic**: unsigned, no saturation. `OUT_W` always holds `BURST`×(2^IN_W − 1), so no overflow is possible. `out_data` and `out_count` keep their last value after the handshake.

## Timing
- `in_ready` and `out_valid` are registered. Neither is combinationally dependent on `in_valid`, `out_ready` or `flush`.
- **Input throughput**: one result per cycle while in ACCUM.
- **Output latency**: `out_valid` is high in the cycle after the edge that accepted the final beat (or sampled `flush`).
- **Minimum input gap**: from the last accepted beat to the next possible accept is 2 cycles (one SEND cycle when `out_ready` is already high).
- **Input stall**: `in_ready` drops at the same edge that accepts the final beat, so a beat presented in the following cycle is not accepted.
- **Reset behaviour**:
  - Reset assertion is asynchronous; outputs clear without waiting for an edge.
  - Release must be synchronous to `clk`; the first edge after release executes IDLE.
- **Output hold**: `out_ready` held low for any number of cycles leaves `out_*` unchanged and `in_ready`=0.

## Test plan
- **Reset**: drive `rst`=0 mid-cycle with no clock edge.
  - All outputs go to 0 and `state`=00 immediately.
  - After release: `state`=00 for one edge, then 01 with `in_ready`=1.
- **Full burst**: beats 100, 200, 300, 400 back-to-back, `out_ready`=1.
  - `out_data`=1000, `out_count`=4, `out_valid` high exactly one cycle.
  - `in_ready` low during that cycle, high again the next cycle.
- **Maximum values**: four beats of 511.
  - `out_data`=2044 (11 bits, no wrap), `out_count`=4.
- **Backpressure**: after a burst of 1, 2, 3, 4, hold `out_ready`=0 for 5 cycles while toggling `in_valid` and `flush`.
  - `out_valid`=1 and `out_data`=10 held stable; `in_ready`=0; no beats absorbed.
  - The next burst after release sums from 0.
- **Flush cases**:
  - Beats 7, 9 then `flush` → `out_data`=16, `out_count`=2.
  - Beats 7, 9 then beat 5 with `flush` in the same cycle → `out_data`=21, `out_count`=3.
  - `flush` with no beats accepted → no output.
- **Reset mid-burst**: after beats 10, 20, 30, assert `rst`=0.
  - Outputs clear and the partial sum is lost.
  - Next burst 1, 1, 1, 1 → `out_data`=4.

Source files
------------

// File: rtl/result_accumulator_if.sv
// Handshake bundle between the adder result stream, the accumulator and its sink.
// master drives the inputs and consumes the totals; slave is the accumulator side.
interface result_accumulator_if #(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned BURST = 4
);
    localparam int unsigned OUT_W = IN_W + $clog2(BURST);
    localparam int unsigned CNT_W = $clog2(BURST + 1);

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_count,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_count,
        output out_valid
    );
endinterface

// File: rtl/result_accumulator.sv
// Sums BURST consecutive adder results (or a flushed partial burst) into a wider total
// and emits it with its beat count over a registered valid/ready handshake.
module result_accumulator #(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned BURST = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    result_accumulator_if.slave  bus,
    output logic [1:0]           state_o
);
    localparam int unsigned OUT_W = IN_W + $clog2(BURST);
    localparam int unsigned CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BurstCnt = CNT_W'(BURST);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAccum = 2'b01,
        StSend  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             accept;
    logic [OUT_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        accept      = 1'b0;
        acc_sum     = acc_q;
        cnt_sum     = cnt_q;

        unique case (state_q)
            StIdle: begin
                in_ready_d = 1'b1;
                state_d    = StAccum;
            end
            StAccum: begin
                accept = bus.in_valid && in_ready_q;
                // in_data is only looked at on an accept, so an X there never reaches acc_q
                if (accept) begin
                    acc_sum = acc_q + OUT_W'(bus.in_data);
                    cnt_sum = cnt_q + CNT_W'(1);
                end
                if ((cnt_sum == BurstCnt) || (bus.flush && (cnt_sum != '0))) begin
                    out_data_d  = acc_sum;
                    out_count_d = cnt_sum;
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = StSend;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_sum;
                end
            end
            StSend: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StAccum;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_result_accumulator.sv
// Self-checking bench for result_accumulator: directed scenarios plus a randomized
// run scored against a queue-based model of burst accumulation.
module tb_result_accumulator;
    localparam int unsigned IN_W  = 9;
    localparam int unsigned BURST = 4;
    localparam int unsigned OUT_W = IN_W + $clog2(BURST);
    localparam int unsigned CNT_W = $clog2(BURST + 1);

    logic       clk_i;
    logic       rst_ni;
    logic [1:0] state_o;
    int         checks;
    int         errors;

    result_accumulator_if #(.IN_W(IN_W), .BURST(BURST)) bus ();

    result_accumulator #(.IN_W(IN_W), .BURST(BURST)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .bus     (bus),
        .state_o (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [IN_W-1:0] d, input logic f, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_ni        = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b1, 9'd50, 1'b1, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++;
            $display("FAIL reset_out_data got %0d want 0", bus.out_data); end
        checks++; if (bus.out_count !== '0) begin errors++;
            $display("FAIL reset_out_count got %0d want 0", bus.out_count); end
        checks++; if (state_o !== 2'b00) begin errors++;
            $display("FAIL reset_state got %b want 00", state_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++; if (state_o !== 2'b00) begin errors++;
            $display("FAIL release_state_idle got %b want 00", state_o); end
        @(negedge clk_i);
        checks++; if (state_o !== 2'b01 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL release_accum got state %b ready %b want 01 1", state_o, bus.in_ready); end
    endtask

    task automatic test_full_burst();
        do_reset();
        step(1'b1, 9'd100, 1'b0, 1'b1);
        step(1'b1, 9'd200, 1'b0, 1'b1);
        step(1'b1, 9'd300, 1'b0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL burst_mid got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
        step(1'b1, 9'd400, 1'b0, 1'b1);
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || state_o !== 2'b10) begin
            errors++;
            $display("FAIL burst_emit got valid %b ready %b state %b want 1 0 10",
                     bus.out_valid, bus.in_ready, state_o); end
        checks++; if (bus.out_data !== 11'd1000 || bus.out_count !== 3'd4) begin errors++;
            $display("FAIL burst_total got %0d/%0d want 1000/4", bus.out_data, bus.out_count); end
        // Beat offered during SEND must not be absorbed
        step(1'b1, 9'd77, 1'b0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 11'd1000)
        begin errors++;
            $display("FAIL burst_after got valid %b ready %b data %0d want 0 1 1000",
                     bus.out_valid, bus.in_ready, bus.out_data); end
    endtask

    task automatic test_max_values();
        do_reset();
        repeat (4) step(1'b1, 9'd511, 1'b0, 1'b1);
        checks++; if (bus.out_data !== 11'd2044 || bus.out_count !== 3'd4 || bus.out_valid !== 1'b1)
        begin errors++;
            $display("FAIL max_total got %0d/%0d valid %b want 2044/4 1",
                     bus.out_data, bus.out_count, bus.out_valid); end
        step(1'b0, 9'd0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 9'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(i[0], 9'($urandom_range(511)), ~i[0], 1'b0);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 11'd10 ||
                          bus.in_ready !== 1'b0 || bus.out_count !== 3'd4) begin errors++;
                $display("FAIL hold_%0d got valid %b data %0d cnt %0d ready %b want 1 10 4 0",
                         i, bus.out_valid, bus.out_data, bus.out_count, bus.in_ready); end
        end
        step(1'b0, 9'd0, 1'b0, 1'b1);
        repeat (4) step(1'b1, 9'd5, 1'b0, 1'b1);
        checks++; if (bus.out_data !== 11'd20 || bus.out_valid !== 1'b1) begin errors++;
            $display("FAIL post_hold_total got %0d valid %b want 20 1", bus.out_data, bus.out_valid); end
        step(1'b0, 9'd0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b1, 9'd7, 1'b0, 1'b1);
        step(1'b1, 9'd9, 1'b0, 1'b1);
        step(1'b0, 9'd300, 1'b1, 1'b1);
        checks++; if (bus.out_data !== 11'd16 || bus.out_count !== 3'd2 || bus.out_valid !== 1'b1)
        begin errors++;
            $display("FAIL flush_partial got %0d/%0d valid %b want 16/2 1",
                     bus.out_data, bus.out_count, bus.out_valid); end
        step(1'b0, 9'd0, 1'b0, 1'b1);
        step(1'b1, 9'd7, 1'b0, 1'b1);
        step(1'b1, 9'd9, 1'b0, 1'b1);
        step(1'b1, 9'd5, 1'b1, 1'b1);
        checks++; if (bus.out_data !== 11'd21 || bus.out_count !== 3'd3 || bus.out_valid !== 1'b1)
        begin errors++;
            $display("FAIL flush_same_cycle got %0d/%0d valid %b want 21/3 1",
                     bus.out_data, bus.out_count, bus.out_valid); end
        step(1'b0, 9'd0, 1'b0, 1'b1);
        step(1'b0, 9'd0, 1'b1, 1'b1);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || state_o !== 2'b01) begin
            errors++;
            $display("FAIL flush_empty got valid %b ready %b state %b want 0 1 01",
                     bus.out_valid, bus.in_ready, state_o); end
        for (int i = 1; i <= 3; i++) step(1'b1, 9'(i), 1'b0, 1'b1);
        step(1'b1, 9'd4, 1'b1, 1'b1);
        checks++; if (bus.out_data !== 11'd10 || bus.out_count !== 3'd4) begin errors++;
            $display("FAIL flush_last_beat got %0d/%0d want 10/4", bus.out_data, bus.out_count); end
        step(1'b0, 9'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        step(1'b1, 9'd10, 1'b0, 1'b1);
        step(1'b1, 9'd20, 1'b0, 1'b1);
        step(1'b1, 9'd30, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || state_o !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset got ready %b valid %b state %b want 0 0 00",
                     bus.in_ready, bus.out_valid, state_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        repeat (4) step(1'b1, 9'd1, 1'b0, 1'b1);
        checks++; if (bus.out_data !== 11'd4 || bus.out_count !== 3'd4 || bus.out_valid !== 1'b1)
        begin errors++;
            $display("FAIL mid_reset_next got %0d/%0d valid %b want 4/4 1",
                     bus.out_data, bus.out_count, bus.out_valid); end
        step(1'b0, 9'd0, 1'b0, 1'b1);
    endtask

    // Model: a burst is the list of accepted beats; while a total is pending nothing is taken.
    task automatic test_random();
        int               beats[$];
        bit               busy;
        logic [OUT_W-1:0] exp_data;
        logic [CNT_W-1:0] exp_cnt;
        logic             v, f, r;
        logic [IN_W-1:0]  d;
        int               s;
        do_reset();
        busy     = 1'b0;
        exp_data = '0;
        exp_cnt  = '0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(3) != 0);
            f = ($urandom_range(7) == 0);
            r = ($urandom_range(1) == 1);
            d = IN_W'($urandom_range(511));
            if (!busy) begin
                if (v) beats.push_back(int'(d));
                if (beats.size() == BURST || (f && beats.size() > 0)) begin
                    s = 0;
                    foreach (beats[k]) s += beats[k];
                    exp_data = OUT_W'(s);
                    exp_cnt  = CNT_W'(beats.size());
                    busy     = 1'b1;
                    beats.delete();
                end
            end else if (r) begin
                busy = 1'b0;
            end
            step(v, d, f, r);
            checks++; if (bus.in_ready !== !busy || bus.out_valid !== busy) begin errors++;
                $display("FAIL rand_hs_%0d got ready %b valid %b want %b %b",
                         i, bus.in_ready, bus.out_valid, !busy, busy); end
            checks++; if (bus.out_data !== exp_data || bus.out_count !== exp_cnt) begin errors++;
                $display("FAIL rand_out_%0d got %0d/%0d want %0d/%0d",
                         i, bus.out_data, bus.out_count, exp_data, exp_cnt); end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_ni        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_full_burst();
        test_max_values();
        test_backpressure();
        test_flush();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
